vga_stream_gen: RTL
===================

// Module: vga_stream_gen
// PURPOSE
//  Timing source for the pixel pipeline. Generates the 23-bit VGA stream (active, VS, HS, YC, XC)
//  that every downstream drawing stage consumes and extends into the 26-bit RGB stream.
//  It sits at the head of the chain, right after the pixel-clock PLL. Default timing is SVGA 800x600@60 (40 MHz).
// PARAMETERS
//  H_ACTIVE  800  visible pixels per line
//  H_FP      40   horizontal front porch (px)
//  H_SYNC    128  horizontal sync width (px)
//  H_BP      88   horizontal back porch (px)
//  V_ACTIVE  600  visible lines per frame
//  V_FP      1    vertical front porch (lines)
//  V_SYNC    4    vertical sync width (lines)
//  V_BP      23   vertical back porch (lines)
//  HS_POL    1    HS level while asserted (1 = positive)
//  VS_POL    1    VS level while asserted (1 = positive)
// PORTS
//  px_clk       in   1   pixel clock; only clock
//  reset        in   1   asynchronous, active-high reset
//  ce           in   1   pixel advance enable; counters and stream move only when 1
//  strVGA       out  23  stream: [0] active, [1] VS, [2] HS, [12:3] YC, [22:13] XC
//  line_start   out  1   1-cycle pulse when strVGA shows XC=0 of any line
//  frame_start  out  1   1-cycle pulse when strVGA shows XC=0, YC=0
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
//  - Internal counters h_cnt and v_cnt are 11-bit. Elaboration fails if either total exceeds 2048.
//  - Reset (async):
//    - h_cnt = 0, v_cnt = 0.
//    - strVGA: active = 0, HS = ~HS_POL, VS = ~VS_POL, XC = 0, YC = 0.
//    - line_start = 0, frame_start = 0.
//  - On a px_clk edge with ce = 1, the output register loads from the current counter values.
//    On the same edge the counters advance. Latency from counter to stream is 1 cycle.
//    The first ce edge after reset presents pixel (0,0) with active = 1.
//  - Advance:
//    - h_cnt = H_TOTAL-1 wraps to 0 and v_cnt increments.
//    - v_cnt = V_TOTAL-1 together with the h wrap takes v_cnt to 0.
//  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
//  - HS = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
//  - VS = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
//    VS is whole-line aligned and changes with the h wrap.
//  - XC = min(h_cnt, 1023) and YC = min(v_cnt, 1023): saturate, never truncate.
//  - ce = 0: counters and strVGA hold. line_start and frame_start are driven 0 on that edge,
//    so each pulse lasts exactly one cycle.
//  - Reset asserted mid-frame: immediate return to the reset values. Restart is at (0,0), no partial line.
// STRUCTURE
//  - Shared package:
//    - stream bit-field localparams (ACTIVE 0, VS 1, HS 2, YC 12:3, XC 22:13, R/G/B 23..25, VGA 22:0, RGB 25:23);
//    - SVGA default timing constants.
//  - One sub-module, sync_counter: 11-bit wrap counter with terminal-count output and advance input.
//    Instantiate it twice. The h terminal count gates the v advance.
//  - Sync/active decode and the output register stay in the top module.
// TESTING
//  1. Reset, then release with ce=1 -> first output strVGA = {XC=0, YC=0, HS=0, VS=0, active=1};
//     frame_start = 1 and line_start = 1 for that one cycle.
//  2. Run one line -> active falls when XC goes 799->800.
//     HS = 1 for exactly 128 cycles, with XC from 840 to 967.
//  3. Line wrap -> after 1056 ce cycles XC returns to 0 and YC = 1. XC reads 1023 for h_cnt 1023..1055.
//  4. Full frame -> VS = 1 on lines 601..604 only.
//     frame_start recurs every 1056*628 = 663168 ce cycles.
//  5. ce toggled 1/0 each cycle -> stream advances every 2 clocks and pulses stay 1 cycle wide.
//     Repeat with HS_POL=0 and VS_POL=0 -> sync levels invert.
//  6. Assert reset at XC=500, YC=300 -> outputs immediately take the reset values.
//     The first ce edge after release presents (0,0) with frame_start = 1.

Source files
------------

// File: rtl/vga_stream_gen_pkg.sv
// Shared definitions for the VGA timing source: stream bit-field layout,
// SVGA 800x600@60 default timing and coordinate helpers.
package vga_stream_gen_pkg;

    // Stream bit fields shared with the downstream drawing stages
    localparam int unsigned STR_ACTIVE  = 0;
    localparam int unsigned STR_VS      = 1;
    localparam int unsigned STR_HS      = 2;
    localparam int unsigned STR_YC_LSB  = 3;
    localparam int unsigned STR_YC_MSB  = 12;
    localparam int unsigned STR_XC_LSB  = 13;
    localparam int unsigned STR_XC_MSB  = 22;
    localparam int unsigned STR_R       = 23;
    localparam int unsigned STR_G       = 24;
    localparam int unsigned STR_B       = 25;
    localparam int unsigned STR_VGA_MSB = 22;
    localparam int unsigned STR_VGA_W   = 23;
    localparam int unsigned STR_RGB_MSB = 25;
    localparam int unsigned STR_RGB_LSB = 23;
    localparam int unsigned STR_RGB_W   = 26;

    localparam int unsigned SVGA_H_ACTIVE = 800;
    localparam int unsigned SVGA_H_FP     = 40;
    localparam int unsigned SVGA_H_SYNC   = 128;
    localparam int unsigned SVGA_H_BP     = 88;
    localparam int unsigned SVGA_V_ACTIVE = 600;
    localparam int unsigned SVGA_V_FP     = 1;
    localparam int unsigned SVGA_V_SYNC   = 4;
    localparam int unsigned SVGA_V_BP     = 23;

    localparam int unsigned CNT_W     = 11;
    localparam int unsigned CNT_LIMIT = 2048;
    localparam int unsigned COORD_W   = 10;

    // Counts above the 10-bit coordinate range clamp to 1023 instead of wrapping
    function automatic logic [COORD_W-1:0] sat_coord(input logic [CNT_W-1:0] cnt);
        return (cnt[CNT_W-1]) ? {COORD_W{1'b1}} : cnt[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/vga_stream_gen_if.sv
// Stream-side bundle of the VGA timing source: pixel enable in, VGA stream and
// line/frame start pulses out.
interface vga_stream_gen_if;
    import vga_stream_gen_pkg::*;

    logic                 ce;
    logic [STR_VGA_W-1:0] strVGA;
    logic                 line_start;
    logic                 frame_start;

    modport master (
        input  ce,
        output strVGA,
        output line_start,
        output frame_start
    );

    modport slave (
        output ce,
        input  strVGA,
        input  line_start,
        input  frame_start
    );

endinterface

// File: rtl/vga_stream_gen_sync_counter.sv
// 11-bit wrap counter: advances when adv_i is high, wraps from Total-1 to 0,
// and flags the terminal count so a following counter can be chained.
module sync_counter
    import vga_stream_gen_pkg::*;
#(
    parameter int unsigned Total = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    if (Total > CNT_LIMIT || Total < 2) begin : g_total_chk
        $error("sync_counter: Total %0d out of range for an 11-bit counter", Total);
    end

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(Total - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (adv_i) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == LastCnt);

endmodule

// File: rtl/vga_stream_gen.sv
// Head of the pixel pipeline: chained h/v counters feed a sync/active decode,
// registered into the 23-bit VGA stream with line and frame start pulses.
module vga_stream_gen
    import vga_stream_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE = SVGA_H_ACTIVE,
    parameter int unsigned H_FP     = SVGA_H_FP,
    parameter int unsigned H_SYNC   = SVGA_H_SYNC,
    parameter int unsigned H_BP     = SVGA_H_BP,
    parameter int unsigned V_ACTIVE = SVGA_V_ACTIVE,
    parameter int unsigned V_FP     = SVGA_V_FP,
    parameter int unsigned V_SYNC   = SVGA_V_SYNC,
    parameter int unsigned V_BP     = SVGA_V_BP,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic              px_clk,
    input  logic              reset,
    vga_stream_gen_if.master  bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] HActEnd    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VActEnd    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [STR_VGA_W-1:0] ResetStr = {{COORD_W{1'b0}}, {COORD_W{1'b0}},
                                                 ~HS_POL, ~VS_POL, 1'b0};

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_tc;
    logic             v_adv;
    logic             unused_v_tc;

    // The vertical counter only steps on the last pixel of a line
    assign v_adv = bus.ce & h_tc;

    sync_counter #(
        .Total (H_TOTAL)
    ) u_h_cnt (
        .clk_i (px_clk),
        .rst_i (reset),
        .adv_i (bus.ce),
        .cnt_o (h_cnt),
        .tc_o  (h_tc)
    );

    sync_counter #(
        .Total (V_TOTAL)
    ) u_v_cnt (
        .clk_i (px_clk),
        .rst_i (reset),
        .adv_i (v_adv),
        .cnt_o (v_cnt),
        .tc_o  (unused_v_tc)
    );

    logic [STR_VGA_W-1:0] str_d, str_q;
    logic                 line_start_d, line_start_q;
    logic                 frame_start_d, frame_start_q;
    logic                 act, hs_on, vs_on;

    always_comb begin
        act   = (h_cnt < HActEnd) && (v_cnt < VActEnd);
        hs_on = (h_cnt >= HSyncStart) && (h_cnt < HSyncEnd);
        vs_on = (v_cnt >= VSyncStart) && (v_cnt < VSyncEnd);

        str_d         = str_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (bus.ce) begin
            str_d[STR_XC_MSB:STR_XC_LSB] = sat_coord(h_cnt);
            str_d[STR_YC_MSB:STR_YC_LSB] = sat_coord(v_cnt);
            str_d[STR_HS]                = hs_on ? HS_POL : ~HS_POL;
            str_d[STR_VS]                = vs_on ? VS_POL : ~VS_POL;
            str_d[STR_ACTIVE]            = act;
            line_start_d                 = (h_cnt == '0);
            frame_start_d                = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge px_clk or posedge reset) begin
        if (reset) begin
            str_q         <= ResetStr;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            str_q         <= str_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.strVGA      = str_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;

endmodule
